// File: rtl/etapa_mem.sv
// MEM pipeline stage: byte-addressable data memory with store lane merging, load filtering and a MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN adds misalignment detection (o_Misaligned) and suppression of misaligned accesses.
module etapa_mem #(
    parameter int NBITS     = 32,
    parameter int REGS      = 5,
    parameter int MEM_WORDS = 256
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NBITS-1:0]             i_ALU,
    input  logic [NBITS-1:0]             i_Registro2,
    input  logic [REGS-1:0]              i_RegistroDestino,
    input  logic [NBITS-1:0]             i_PC4,
    input  logic [NBITS-1:0]             i_PCBranch,
    input  logic                         i_Cero,
    input  logic                         i_Branch,
    input  logic                         i_MemWrite,
    input  logic                         i_MemRead,
    input  logic [1:0]                   i_TamanoFiltro,
    input  logic                         i_MemToReg,
    input  logic                         i_RegWrite,
    input  logic [1:0]                   i_TamanoFiltroL,
    input  logic                         i_ZeroExtend,
    input  logic [$clog2(MEM_WORDS)-1:0] i_DebugAddr,
    output logic                         o_PCSrc,
    output logic [NBITS-1:0]             o_PCBranch,
    output logic [NBITS-1:0]             o_ReadData,
    output logic [NBITS-1:0]             o_ALU,
    output logic [NBITS-1:0]             o_PC4,
    output logic [REGS-1:0]              o_RegistroDestino,
    output logic                         o_MemToReg,
    output logic                         o_RegWrite,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                         o_Misaligned,
`endif
    output logic [NBITS-1:0]             o_DebugData
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LANES = NBITS / 8;

    logic [NBITS-1:0] mem [MEM_WORDS];

    logic [AW-1:0]    word_idx;
    logic [1:0]       lane;
    logic [NBITS-1:0] rd_word;
    logic [NBITS-1:0] wr_word;
    logic [LANES-1:0] wr_mask;
    logic [NBITS-1:0] wr_data;
    logic             wr_en;
    logic [NBITS-1:0] load_data;
    logic             mis_wr;
    logic             mis_rd;

    logic [NBITS-1:0] read_data_p1;
    logic [NBITS-1:0] alu_p1;
    logic [NBITS-1:0] pc4_p1;
    logic [REGS-1:0]  rd_p1;
    logic             mem_to_reg_p1;
    logic             reg_write_p1;
    logic             misaligned_p1;

    // Byte-enable mask for a store of the given size at the given lane.
    function automatic logic [LANES-1:0] store_mask(input logic [1:0] size, input logic [1:0] ln);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            case (size)
                2'b00:   m[k] = (k == int'(ln));
                2'b01:   m[k] = ((k / 2) == int'(ln[1]));
                default: m[k] = 1'b1;
            endcase
        end
        return m;
    endfunction

    // Store data replicated into every lane so the mask alone selects placement.
    function automatic logic [NBITS-1:0] store_place(input logic [1:0] size, input logic [NBITS-1:0] d);
        logic [NBITS-1:0] r;
        case (size)
            2'b00:   r = {LANES{d[7:0]}};
            2'b01:   r = {(LANES/2){d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [NBITS-1:0] load_extend(input logic [1:0] size, input logic [NBITS-1:0] w,
                                                     input logic [1:0] ln, input logic zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [NBITS-1:0]   r;
        b = w[8*int'(ln) +: 8];
        h = w[16*int'(ln[1]) +: 16];
        case (size)
            2'b00:   r = zext ? {{(NBITS-8){1'b0}}, b}  : {{(NBITS-8){b[7]}}, b};
            2'b01:   r = zext ? {{(NBITS-16){1'b0}}, h} : {{(NBITS-16){h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ln);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = ln[0];
            default: r = |ln;
        endcase
        return r;
    endfunction

    assign mis_wr = i_MemWrite & is_misaligned(i_TamanoFiltro, lane);
    assign mis_rd = i_MemRead & is_misaligned(i_TamanoFiltroL, lane);
`else
    assign mis_wr = 1'b0;
    assign mis_rd = 1'b0;
`endif

    assign o_PCSrc    = i_Branch & i_Cero;
    assign o_PCBranch = i_PCBranch;

    // Upper address bits are dropped, so addresses wrap modulo the memory depth.
    assign word_idx = i_ALU[AW+1:2];
    assign lane     = i_ALU[1:0];
    assign rd_word  = mem[word_idx];

    assign wr_mask = store_mask(i_TamanoFiltro, lane);
    assign wr_data = store_place(i_TamanoFiltro, i_Registro2);
    assign wr_en   = i_MemWrite & ~mis_wr;

    always_comb begin
        wr_word = rd_word;
        for (int k = 0; k < LANES; k++) begin
            if (wr_mask[k]) begin
                wr_word[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    assign load_data = (i_MemRead && !mis_rd)
                       ? load_extend(i_TamanoFiltroL, rd_word, lane, i_ZeroExtend)
                       : '0;

    // Memory write: rising edge. Loads sample at the falling edge earlier in the
    // same cycle, which gives read-before-write for a store/load to one word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (wr_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    // MEM/WB register: falling edge.
    always_ff @(negedge i_clk) begin
        if (!i_reset) begin
            read_data_p1  <= '0;
            alu_p1        <= '0;
            pc4_p1        <= '0;
            rd_p1         <= '0;
            mem_to_reg_p1 <= 1'b0;
            reg_write_p1  <= 1'b0;
            misaligned_p1 <= 1'b0;
        end else begin
            read_data_p1  <= load_data;
            alu_p1        <= i_ALU;
            pc4_p1        <= i_PC4;
            rd_p1         <= i_RegistroDestino;
            mem_to_reg_p1 <= i_MemToReg;
            reg_write_p1  <= i_RegWrite;
            misaligned_p1 <= mis_wr | mis_rd;
        end
    end

    assign o_ReadData        = read_data_p1;
    assign o_ALU             = alu_p1;
    assign o_PC4             = pc4_p1;
    assign o_RegistroDestino = rd_p1;
    assign o_MemToReg        = mem_to_reg_p1;
    assign o_RegWrite        = reg_write_p1;
`ifdef MEM_ALIGN_CHECK_EN
    assign o_Misaligned      = misaligned_p1;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned_p1;
`endif

    assign o_DebugData = mem[i_DebugAddr];

endmodule
